// File: rtl/wb_load_commit.sv
// Writeback stage: picks ALU result or aligned load data, drives a registered RF write port,
// and stalls upstream while a load waits for its response. Optional watchdog: WB_TIMEOUT_EN.
module wb_load_commit #(
  parameter logic [5:0] ID_LB          = 6'd10,
  parameter logic [5:0] ID_LH          = 6'd11,
  parameter logic [5:0] ID_LW          = 6'd12,
  parameter logic [5:0] ID_LBU         = 6'd13,
  parameter logic [5:0] ID_LHU         = 6'd14,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr_in,
  input  logic        rd_valid_in,
  input  logic [5:0]  instr_id_in,
  input  logic [31:0] exec_output_in,
  input  logic [31:0] mem_addr_in,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        wb_stall,
  output logic        wb_timeout_err
);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  state_t      state_reg;
  logic [4:0]  cap_rd_reg;
  logic        cap_valid_reg;
  logic [5:0]  cap_id_reg;
  logic [1:0]  cap_off_reg;

  logic [7:0]  rsp_bytes [4];
  logic        is_load_in;
  logic        commit_in;
  logic        commit_cap;
  logic [5:0]  sel_id;
  logic [1:0]  sel_off;
  logic [15:0] sel_half;
  logic [7:0]  sel_byte;
  logic [31:0] aligned_data;
  logic        timeout_hit;
  logic        unused_bits;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rsp_bytes[gi] = mem_rsp_data[8*gi +: 8];
    end
  endgenerate

  assign is_load_in = (instr_id_in == ID_LB) || (instr_id_in == ID_LH) ||
                      (instr_id_in == ID_LW) || (instr_id_in == ID_LBU) ||
                      (instr_id_in == ID_LHU);
  assign commit_in  = rd_valid_in && (rd_addr_in != 5'd0);
  assign commit_cap = cap_valid_reg && (cap_rd_reg != 5'd0);

  // While waiting, upstream holds stale inputs, so alignment uses the captured fields.
  assign sel_id   = (state_reg == WAIT_RSP) ? cap_id_reg  : instr_id_in;
  assign sel_off  = (state_reg == WAIT_RSP) ? cap_off_reg : mem_addr_in[1:0];
  assign sel_byte = rsp_bytes[sel_off];
  assign sel_half = sel_off[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];

  always_comb begin
    aligned_data = mem_rsp_data;
    if (sel_id == ID_LB)       aligned_data = {{24{sel_byte[7]}}, sel_byte};
    else if (sel_id == ID_LBU) aligned_data = {24'd0, sel_byte};
    else if (sel_id == ID_LH)  aligned_data = {{16{sel_half[15]}}, sel_half};
    else if (sel_id == ID_LHU) aligned_data = {16'd0, sel_half};
  end

  assign wb_stall = !rst && !mem_rsp_valid &&
                    (((state_reg == IDLE) && is_load_in) || (state_reg == WAIT_RSP));

`ifdef WB_TIMEOUT_EN
  logic [7:0] wait_cnt_reg;
  logic       timeout_err_reg;

  assign timeout_hit    = (state_reg == WAIT_RSP) && !mem_rsp_valid &&
                          (wait_cnt_reg == 8'(TIMEOUT_CYCLES - 1));
  assign wb_timeout_err = timeout_err_reg;
  assign unused_bits    = ^mem_addr_in[31:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg    <= 8'd0;
      timeout_err_reg <= 1'b0;
    end else if ((state_reg == IDLE) && is_load_in && !mem_rsp_valid) begin
      wait_cnt_reg <= 8'd0;
    end else if ((state_reg == WAIT_RSP) && !mem_rsp_valid) begin
      if (timeout_hit) timeout_err_reg <= 1'b1;
      else             wait_cnt_reg    <= wait_cnt_reg + 8'd1;
    end
  end
`else
  assign timeout_hit    = 1'b0;
  assign wb_timeout_err = 1'b0;
  assign unused_bits    = ^{mem_addr_in[31:2], 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cap_rd_reg    <= 5'd0;
      cap_valid_reg <= 1'b0;
      cap_id_reg    <= 6'd0;
      cap_off_reg   <= 2'd0;
      rf_wr_en      <= 1'b0;
      rf_wr_addr    <= 5'd0;
      rf_wr_data    <= 32'd0;
    end else begin
      rf_wr_en <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!is_load_in) begin
            if (commit_in) begin
              rf_wr_en   <= 1'b1;
              rf_wr_addr <= rd_addr_in;
              rf_wr_data <= exec_output_in;
            end
          end else if (mem_rsp_valid) begin
            if (commit_in) begin
              rf_wr_en   <= 1'b1;
              rf_wr_addr <= rd_addr_in;
              rf_wr_data <= aligned_data;
            end
          end else begin
            cap_rd_reg    <= rd_addr_in;
            cap_valid_reg <= rd_valid_in;
            cap_id_reg    <= instr_id_in;
            cap_off_reg   <= mem_addr_in[1:0];
            state_reg     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            if (commit_cap) begin
              rf_wr_en   <= 1'b1;
              rf_wr_addr <= cap_rd_reg;
              rf_wr_data <= aligned_data;
            end
            state_reg <= IDLE;
          end else if (timeout_hit) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_load_commit.sv
// Directed bench for wb_load_commit; watchdog cases run only when WB_TIMEOUT_EN is defined.
module tb_wb_load_commit;

  localparam logic [5:0] ID_ALU = 6'd1;
  localparam logic [5:0] ID_LB  = 6'd10;
  localparam logic [5:0] ID_LH  = 6'd11;
  localparam logic [5:0] ID_LW  = 6'd12;
  localparam logic [5:0] ID_LBU = 6'd13;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_in;
  logic        rd_valid_in;
  logic [5:0]  instr_id_in;
  logic [31:0] exec_output_in;
  logic [31:0] mem_addr_in;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        wb_stall;
  logic        wb_timeout_err;

  int total = 0;
  int bad   = 0;

  wb_load_commit dut (
    .clk(clk), .rst(rst),
    .rd_addr_in(rd_addr_in), .rd_valid_in(rd_valid_in), .instr_id_in(instr_id_in),
    .exec_output_in(exec_output_in), .mem_addr_in(mem_addr_in),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .wb_stall(wb_stall), .wb_timeout_err(wb_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Apply one set of inputs and let combinational outputs settle.
  task automatic drive(input logic [4:0] rd, input logic rv, input logic [5:0] id,
                       input logic [31:0] ex, input logic [31:0] addr,
                       input logic mv, input logic [31:0] md);
    rd_addr_in = rd; rd_valid_in = rv; instr_id_in = id;
    exec_output_in = ex; mem_addr_in = addr; mem_rsp_valid = mv; mem_rsp_data = md;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(5'd0, 1'b0, ID_ALU, 32'd0, 32'd0, 1'b0, 32'd0);
    check("reset_en", {31'd0, rf_wr_en}, 32'd0);
    check("reset_addr", {27'd0, rf_wr_addr}, 32'd0);
    check("reset_data", rf_wr_data, 32'd0);
    check("reset_stall", {31'd0, wb_stall}, 32'd0);
    check("reset_err", {31'd0, wb_timeout_err}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // ALU commit, then rd=0 must not write and must leave addr/data held
    drive(5'd5, 1'b1, ID_ALU, 32'h1234ABCD, 32'd0, 1'b0, 32'd0);
    check("alu_stall", {31'd0, wb_stall}, 32'd0);
    tick();
    check("alu_en", {31'd0, rf_wr_en}, 32'd1);
    check("alu_addr", {27'd0, rf_wr_addr}, 32'd5);
    check("alu_data", rf_wr_data, 32'h1234ABCD);
    drive(5'd0, 1'b1, ID_ALU, 32'h00000055, 32'd0, 1'b0, 32'd0);
    tick();
    check("x0_en", {31'd0, rf_wr_en}, 32'd0);
    check("x0_addr_hold", {27'd0, rf_wr_addr}, 32'd5);
    check("x0_data_hold", rf_wr_data, 32'h1234ABCD);

    // Same-cycle byte loads
    drive(5'd7, 1'b1, ID_LB, 32'd0, 32'h00001003, 1'b1, 32'h80FF0011);
    check("lb_stall", {31'd0, wb_stall}, 32'd0);
    tick();
    check("lb_en", {31'd0, rf_wr_en}, 32'd1);
    check("lb_addr", {27'd0, rf_wr_addr}, 32'd7);
    check("lb_data", rf_wr_data, 32'hFFFFFF80);
    drive(5'd8, 1'b1, ID_LBU, 32'd0, 32'h00001003, 1'b1, 32'h80FF0011);
    tick();
    check("lbu_data", rf_wr_data, 32'h00000080);
    drive(5'd8, 1'b1, ID_LBU, 32'd0, 32'h00001002, 1'b1, 32'h80FF0011);
    tick();
    check("lbu_off2_data", rf_wr_data, 32'h000000FF);

    // LH with a late response; inputs change during the stall
    drive(5'd9, 1'b1, ID_LH, 32'd0, 32'h00002002, 1'b0, 32'd0);
    check("lh_stall_c1", {31'd0, wb_stall}, 32'd1);
    tick();
    check("lh_en_c1", {31'd0, rf_wr_en}, 32'd0);
    drive(5'd3, 1'b1, ID_ALU, 32'h0000AAAA, 32'h00000000, 1'b0, 32'd0);
    check("lh_stall_c2", {31'd0, wb_stall}, 32'd1);
    tick();
    check("lh_en_c2", {31'd0, rf_wr_en}, 32'd0);
    check("lh_stall_c3", {31'd0, wb_stall}, 32'd1);
    tick();
    check("lh_en_c3", {31'd0, rf_wr_en}, 32'd0);
    drive(5'd3, 1'b1, ID_ALU, 32'h0000AAAA, 32'h00000000, 1'b1, 32'hBEEF0000);
    check("lh_stall_rsp", {31'd0, wb_stall}, 32'd0);
    tick();
    check("lh_en", {31'd0, rf_wr_en}, 32'd1);
    check("lh_addr", {27'd0, rf_wr_addr}, 32'd9);
    check("lh_data", rf_wr_data, 32'hFFFFBEEF);
    drive(5'd0, 1'b0, ID_ALU, 32'd0, 32'd0, 1'b0, 32'd0);
    tick();
    check("lh_pulse_end", {31'd0, rf_wr_en}, 32'd0);

    // LW ignores offset; stray response in IDLE is ignored
    drive(5'd10, 1'b1, ID_LW, 32'd0, 32'h00003003, 1'b1, 32'hDEADBEEF);
    tick();
    check("lw_data", rf_wr_data, 32'hDEADBEEF);
    drive(5'd11, 1'b0, ID_ALU, 32'h77777777, 32'd0, 1'b1, 32'h12345678);
    tick();
    check("stray_en", {31'd0, rf_wr_en}, 32'd0);
    check("stray_data_hold", rf_wr_data, 32'hDEADBEEF);

    // Reset while waiting discards the load
    drive(5'd12, 1'b1, ID_LW, 32'd0, 32'h00004000, 1'b0, 32'd0);
    tick();
    check("rstwait_stall", {31'd0, wb_stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstwait_stall_drop", {31'd0, wb_stall}, 32'd0);
    check("rstwait_en", {31'd0, rf_wr_en}, 32'd0);
    check("rstwait_addr", {27'd0, rf_wr_addr}, 32'd0);
    #1 rst = 1'b0;
    drive(5'd0, 1'b0, ID_ALU, 32'd0, 32'd0, 1'b1, 32'hCAFEBABE);
    tick();
    check("rstwait_late_rsp", {31'd0, rf_wr_en}, 32'd0);

`ifdef WB_TIMEOUT_EN
    // No response: error after 16 waiting cycles
    drive(5'd13, 1'b1, ID_LW, 32'd0, 32'h00005000, 1'b0, 32'd0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("to_err_before", {31'd0, wb_timeout_err}, 32'd0);
    tick();
    check("to_err", {31'd0, wb_timeout_err}, 32'd1);
    check("to_en", {31'd0, rf_wr_en}, 32'd0);
    drive(5'd0, 1'b0, ID_ALU, 32'd0, 32'd0, 1'b0, 32'd0);
    check("to_idle_stall", {31'd0, wb_stall}, 32'd0);
    tick();
    check("to_err_sticky", {31'd0, wb_timeout_err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Response in the 16th waiting cycle wins
    drive(5'd14, 1'b1, ID_LW, 32'd0, 32'h00006000, 1'b0, 32'd0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    drive(5'd14, 1'b1, ID_LW, 32'd0, 32'h00006000, 1'b1, 32'hCAFEF00D);
    tick();
    check("to_late_en", {31'd0, rf_wr_en}, 32'd1);
    check("to_late_data", rf_wr_data, 32'hCAFEF00D);
    check("to_late_err", {31'd0, wb_timeout_err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
